// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment types, blank pattern and hex decode table.
// Segment vectors are active low, ordered {g,f,e,d,c,b,a}.
package sseg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] digit_idx_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t s;
        case (hex)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// hex_to_sseg: combinational nibble to active-low segment decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: 4-digit common-anode scan driver with per-frame snapshot, ghost blanking and error blink.
// Define SSEG_LZB_EN to enable leading-zero blanking outside error mode.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       is_err,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [3:0] an,
    output seg_t       seg,
    output logic       frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]   presc;
    digit_idx_t      idx;
    logic [3:0][3:0] shadow;
    logic            shadow_err;
    logic [BW-1:0]   blink_cnt;
    logic            phase;
    logic            slot_tick;
    logic            frame_end;
    logic            blink_run;
    logic            lzb;
    seg_t            dec;

    assign slot_tick = presc == P_LAST;
    assign frame_end = slot_tick && idx == 2'd3;
    // Blinking only advances across consecutive error frames; entering error mode starts visible.
    assign blink_run = is_err && shadow_err;

`ifdef SSEG_LZB_EN
    assign lzb = !shadow_err && (idx == 2'd3 ? shadow[3] == 4'h0 :
                                 idx == 2'd2 ? shadow[3] == 4'h0 && shadow[2] == 4'h0 :
                                 idx == 2'd1 ? shadow[3] == 4'h0 && shadow[2] == 4'h0 && shadow[1] == 4'h0 :
                                 1'b0);
`else
    assign lzb = 1'b0;
`endif

    hex_to_sseg u_dec (
        .hex (shadow[idx]),
        .seg (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            idx        <= '0;
            shadow     <= '0;
            shadow_err <= 1'b0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            an         <= 4'hF;
            seg        <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            presc      <= slot_tick ? '0 : presc + 1'b1;
            idx        <= slot_tick ? idx + 1'b1 : idx;
            frame_tick <= frame_end;
            if (frame_end) begin
                shadow     <= {digit3, digit2, digit1, digit0};
                shadow_err <= is_err;
                blink_cnt  <= (blink_run && blink_cnt != B_LAST) ? blink_cnt + 1'b1 : '0;
                phase      <= blink_run && (phase ^ (blink_cnt == B_LAST));
            end
            // The slot after a terminal count starts with one dark cycle to hide ghosting.
            an  <= (slot_tick || phase) ? 4'hF : ~(4'b0001 << idx);
            seg <= (slot_tick || lzb) ? SEG_BLANK : dec;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: randomized self-checking bench against a cycle-count based reference model.
module tb_sseg_scan_driver;

    localparam int DIV   = 4;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       is_err = 1'b0;
    logic [3:0] digit0 = 4'h0;
    logic [3:0] digit1 = 4'h0;
    logic [3:0] digit2 = 4'h0;
    logic [3:0] digit3 = 4'h0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    int         k;
    logic [3:0] m_sh [4];
    bit         m_err;
    int         run;

    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    sseg_scan_driver #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .reset      (reset),
        .is_err     (is_err),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %0h exp %0h", tag, k, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        logic [6:0] s = 7'h7F;
        string      l = lit[h];
        for (int j = 0; j < l.len(); j++) s[int'(l[j]) - 97] = 1'b0;
        return s;
    endfunction

    function automatic bit ref_lzb(input int i);
`ifdef SSEG_LZB_EN
        bit z = !m_err && i > 0;
        for (int j = i; j < 4; j++) z = z && m_sh[j] == 4'h0;
        return z;
`else
        return i < 0;
`endif
    endfunction

    task automatic check_outputs();
        logic [3:0] ea = 4'hF;
        logic [6:0] es = 7'h7F;
        bit         ph = ((run / BF) % 2) == 1;
        if (k > 0 && (k - 1) % DIV != DIV - 1) begin
            int i = ((k - 1) / DIV) % 4;
            ea = ph ? 4'hF : ~(4'b0001 << i);
            es = ref_lzb(i) ? 7'h7F : ref_seg(m_sh[i]);
        end
        check("an", 32'(an), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("frame_tick", 32'(frame_tick), 32'(k > 0 && k % FRAME == 0));
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            k++;
            if (k % FRAME == 0) begin
                run   = (is_err && m_err) ? run + 1 : 0;
                m_err = is_err;
                m_sh[0] = digit0;
                m_sh[1] = digit1;
                m_sh[2] = digit2;
                m_sh[3] = digit3;
            end
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_ft", 32'(frame_tick), 32'h0);
        repeat (hold) @(negedge clk);
        check("rst_hold_an", 32'(an), 32'hF);
        reset = 1'b0;
        k = 0;
        m_err = 1'b0;
        run = 0;
        for (int j = 0; j < 4; j++) m_sh[j] = 4'h0;
        #1;
        check_outputs();
        @(negedge clk);
        step(0);
        k = 0;
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0, input logic e);
        digit3 = d3;
        digit2 = d2;
        digit1 = d1;
        digit0 = d0;
        is_err = e;
    endtask

    initial begin
        k = 0;
        m_err = 1'b0;
        run = 0;
        for (int j = 0; j < 4; j++) m_sh[j] = 4'h0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        set_digits(4'h3, 4'h2, 4'h1, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_init_an", 32'(an), 32'hF);
        check("rst_init_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        k = 0;
        #1;
        check_outputs();
        step(3 * FRAME);
        step(6);
        digit0 = 4'h8;
        step(3 * FRAME);
        set_digits(4'hE, 4'hC, 4'h0, 4'h1, 1'b1);
        step(8 * FRAME);
        is_err = 1'b0;
        step(2 * FRAME);
        set_digits(4'h0, 4'h0, 4'h4, 4'h7, 1'b0);
        step(2 * FRAME);
        is_err = 1'b1;
        step(2 * FRAME);
        is_err = 1'b0;
        step(FRAME);
        for (int c = 0; c < 30 * FRAME; c++) begin
            if ($urandom_range(7) == 0)
                set_digits($urandom_range(15), $urandom_range(15), $urandom_range(15),
                           $urandom_range(15), $urandom_range(3) == 0);
            if ($urandom_range(15) == 0) set_digits(4'h0, 4'h0, $urandom_range(1), $urandom_range(15), 1'b0);
            step(1);
        end
        while (!(((k / DIV) % 4) == 2 && (k % DIV) == 1)) step(1);
        set_digits(4'h9, 4'hA, 4'hB, 4'hD, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_ft", 32'(frame_tick), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        k = 0;
        m_err = 1'b0;
        run = 0;
        for (int j = 0; j < 4; j++) m_sh[j] = 4'h0;
        #1;
        check_outputs();
        step(3 * FRAME);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
